// File: rtl/ppu_pkg.sv
// PPU VRAM bank shared types.
// Targets, host write entries, commit FSM states.
package ppu_pkg;

  localparam int TB_AW  = 9;
  localparam int TG_AW  = 11;
  localparam int SG_AW  = 11;
  localparam int CP_AW  = 3;
  localparam int OAM_AW = 8;

  localparam int DW     = 32;
  localparam int CP_DW  = 24;
  localparam int SEL_W  = 3;
  localparam int OFF_W  = 11;

  typedef enum logic [SEL_W-1:0] {
    TGT_TB  = 3'd0,
    TGT_TG  = 3'd1,
    TGT_SG  = 3'd2,
    TGT_CP  = 3'd3,
    TGT_OAM = 3'd4
  } target_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [OFF_W-1:0] offset;
    logic [DW-1:0]    data;
  } host_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    HOLD
  } state_t;

endpackage

// File: rtl/ppu_wr_fifo.sv
// Host write queue: show-ahead sync FIFO.
// Head entry is visible combinationally.
module ppu_wr_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  host_entry_t wdata,
  input  logic        pop,
  output host_entry_t rdata,
  output logic        full,
  output logic        empty,
  output logic [LW-1:0] level
);

  host_entry_t mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [LW-1:0] cnt;
  logic push_ok;
  logic pop_ok;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rp];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // entry storage, never cleared
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ppu_vram_bank.sv
// PPU memory responder: five VRAMs plus a
// host write queue committed only in vblank.
module ppu_vram_bank
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TB_DEPTH   = 512,
  parameter int TG_DEPTH   = 2048,
  parameter int SG_DEPTH   = 2048,
  parameter int CP_DEPTH   = 8,
  parameter int OAM_DEPTH  = 256,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic [13:0]       address,
  input  logic [DW-1:0]     writedata,
  output logic              waitrequest,
  input  logic              vblank,
  input  logic              rw_tile_buffer,
  input  logic              rw_tile_graphics,
  input  logic              rw_sprite_graphics,
  input  logic              rw_color_palettes,
  input  logic              rw_OAM,
  input  logic [TB_AW-1:0]  addr_tile_buffer,
  input  logic [TG_AW-1:0]  addr_tile_graphics,
  input  logic [SG_AW-1:0]  addr_sprite_graphics,
  input  logic [CP_AW-1:0]  addr_color_palettes,
  input  logic [OAM_AW-1:0] addr_OAM,
  input  logic [DW-1:0]     write_data_tile_buffer,
  input  logic [DW-1:0]     write_data_tile_graphics,
  input  logic [DW-1:0]     write_data_sprite_graphics,
  input  logic [DW-1:0]     write_data_OAM,
  input  logic [CP_DW-1:0]  write_data_color_palettes,
  output logic [DW-1:0]     read_data_tile_buffer,
  output logic [DW-1:0]     read_data_tile_graphics,
  output logic [DW-1:0]     read_data_sprite_graphics,
  output logic [DW-1:0]     read_data_OAM,
  output logic [CP_DW-1:0]  read_data_color_palettes,
  output logic [LW-1:0]     fifo_level,
  output logic              err_sticky
);

  host_entry_t push_d;
  host_entry_t head;
  target_t     tgt;
  state_t      state;

  logic full;
  logic empty;
  logic push;
  logic commit;
  logic conflict;
  logic bad;
  logic h_tb;
  logic h_tg;
  logic h_sg;
  logic h_cp;
  logic h_oam;

  logic [DW-1:0]    tb_mem  [TB_DEPTH];
  logic [DW-1:0]    tg_mem  [TG_DEPTH];
  logic [DW-1:0]    sg_mem  [SG_DEPTH];
  logic [CP_DW-1:0] cp_mem  [CP_DEPTH];
  logic [DW-1:0]    oam_mem [OAM_DEPTH];

  assign push_d = '{
    sel:    address[13:11],
    offset: address[10:0],
    data:   writedata
  };

  assign waitrequest = full;
  assign push = chipselect && write && !full;

  ppu_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_d),
    .pop   (commit),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign tgt = target_t'(head.sel);

  // a PPU write to the head's target blocks the commit
  always_comb begin
    conflict = 1'b0;
    bad      = 1'b0;
    case (tgt)
      TGT_TB:  conflict = rw_tile_buffer;
      TGT_TG:  conflict = rw_tile_graphics;
      TGT_SG:  conflict = rw_sprite_graphics;
      TGT_CP:  conflict = rw_color_palettes;
      TGT_OAM: conflict = rw_OAM;
      default: bad = 1'b1;
    endcase
  end

  assign commit = reset && (state == DRAIN)
               && vblank && !empty && !conflict;

  assign h_tb  = commit && (tgt == TGT_TB);
  assign h_tg  = commit && (tgt == TGT_TG);
  assign h_sg  = commit && (tgt == TGT_SG);
  assign h_cp  = commit && (tgt == TGT_CP);
  assign h_oam = commit && (tgt == TGT_OAM);

  // commit sequencer and sticky bad-select flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      err_sticky <= 1'b0;
    end else begin
      if (commit && bad) err_sticky <= 1'b1;
      case (state)
        IDLE: begin
          if (vblank && !empty) state <= DRAIN;
        end
        DRAIN: begin
          if (!vblank || empty) state <= IDLE;
          else if (conflict)    state <= HOLD;
        end
        HOLD: begin
          state <= vblank ? DRAIN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // tile buffer: PPU port, host commit, registered read
  always_ff @(posedge clk) begin
    if (rw_tile_buffer)
      tb_mem[addr_tile_buffer] <= write_data_tile_buffer;
    else if (h_tb)
      tb_mem[head.offset[TB_AW-1:0]] <= head.data;
    if (!reset)
      read_data_tile_buffer <= '0;
    else if (!rw_tile_buffer)
      read_data_tile_buffer <= tb_mem[addr_tile_buffer];
  end

  // tile graphics: PPU port, host commit, registered read
  always_ff @(posedge clk) begin
    if (rw_tile_graphics)
      tg_mem[addr_tile_graphics] <= write_data_tile_graphics;
    else if (h_tg)
      tg_mem[head.offset[TG_AW-1:0]] <= head.data;
    if (!reset)
      read_data_tile_graphics <= '0;
    else if (!rw_tile_graphics)
      read_data_tile_graphics <= tg_mem[addr_tile_graphics];
  end

  // sprite graphics: PPU port, host commit, registered read
  always_ff @(posedge clk) begin
    if (rw_sprite_graphics)
      sg_mem[addr_sprite_graphics] <= write_data_sprite_graphics;
    else if (h_sg)
      sg_mem[head.offset[SG_AW-1:0]] <= head.data;
    if (!reset)
      read_data_sprite_graphics <= '0;
    else if (!rw_sprite_graphics)
      read_data_sprite_graphics <= sg_mem[addr_sprite_graphics];
  end

  // color palettes: 24-bit entries, host data truncated
  always_ff @(posedge clk) begin
    if (rw_color_palettes)
      cp_mem[addr_color_palettes] <= write_data_color_palettes;
    else if (h_cp)
      cp_mem[head.offset[CP_AW-1:0]] <= head.data[CP_DW-1:0];
    if (!reset)
      read_data_color_palettes <= '0;
    else if (!rw_color_palettes)
      read_data_color_palettes <= cp_mem[addr_color_palettes];
  end

  // OAM: PPU port, host commit, registered read
  always_ff @(posedge clk) begin
    if (rw_OAM)
      oam_mem[addr_OAM] <= write_data_OAM;
    else if (h_oam)
      oam_mem[head.offset[OAM_AW-1:0]] <= head.data;
    if (!reset)
      read_data_OAM <= '0;
    else if (!rw_OAM)
      read_data_OAM <= oam_mem[addr_OAM];
  end

endmodule

// File: tb/tb_ppu_vram_bank.sv
// Self-checking bench for ppu_vram_bank.
// Memory model is a flat array per target.
module tb_ppu_vram_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [13:0] address;
  logic [31:0] writedata;
  logic        waitrequest;
  logic        vblank;
  logic        rw  [5];
  logic [10:0] pa  [5];
  logic [31:0] pwd [5];
  logic [31:0] rd_tb, rd_tg, rd_sg, rd_oam;
  logic [23:0] rd_cp;
  logic [4:0]  fifo_level;
  logic        err_sticky;

  logic [31:0] mdl [5][2048];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppu_vram_bank dut (
    .clk                        (clk),
    .reset                      (reset),
    .chipselect                 (chipselect),
    .write                      (write),
    .address                    (address),
    .writedata                  (writedata),
    .waitrequest                (waitrequest),
    .vblank                     (vblank),
    .rw_tile_buffer             (rw[0]),
    .rw_tile_graphics           (rw[1]),
    .rw_sprite_graphics         (rw[2]),
    .rw_color_palettes          (rw[3]),
    .rw_OAM                     (rw[4]),
    .addr_tile_buffer           (pa[0][8:0]),
    .addr_tile_graphics         (pa[1]),
    .addr_sprite_graphics       (pa[2]),
    .addr_color_palettes        (pa[3][2:0]),
    .addr_OAM                   (pa[4][7:0]),
    .write_data_tile_buffer     (pwd[0]),
    .write_data_tile_graphics   (pwd[1]),
    .write_data_sprite_graphics (pwd[2]),
    .write_data_OAM             (pwd[4]),
    .write_data_color_palettes  (pwd[3][23:0]),
    .read_data_tile_buffer      (rd_tb),
    .read_data_tile_graphics    (rd_tg),
    .read_data_sprite_graphics  (rd_sg),
    .read_data_OAM              (rd_oam),
    .read_data_color_palettes   (rd_cp),
    .fifo_level                 (fifo_level),
    .err_sticky                 (err_sticky)
  );

  function automatic int depth_of(input int m);
    case (m)
      0:       return 512;
      3:       return 8;
      4:       return 256;
      default: return 2048;
    endcase
  endfunction

  function automatic logic [31:0] dmask(input int m);
    return (m == 3) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] get_rd(input int m);
    case (m)
      0:       return rd_tb;
      1:       return rd_tg;
      2:       return rd_sg;
      3:       return {8'h00, rd_cp};
      default: return rd_oam;
    endcase
  endfunction

  // reference: a committed host entry lands at offset mod depth
  task automatic model_host(input int sel, input int off,
                            input logic [31:0] d);
    if (sel <= 4)
      mdl[sel][off % depth_of(sel)] = d & dmask(sel);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ppu(input int m, input logic w,
                         input int a, input logic [31:0] d);
    for (int i = 0; i < 5; i++) rw[i] = 1'b0;
    rw[m]  = w;
    pa[m]  = 11'(a);
    pwd[m] = d;
  endtask

  task automatic ppu_write(input int m, input int a,
                           input logic [31:0] d);
    set_ppu(m, 1'b1, a, d);
    tick();
    rw[m] = 1'b0;
    mdl[m][a] = d & dmask(m);
  endtask

  task automatic ppu_read(input int m, input int a,
                          output logic [31:0] d);
    set_ppu(m, 1'b0, a, 32'h0);
    tick();
    d = get_rd(m);
  endtask

  task automatic host_push(input int sel, input int off,
                           input logic [31:0] d, output bit ok);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = {3'(sel), 11'(off)};
    writedata  = d;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (!waitrequest) ok = 1'b1;
      tick();
    end
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic wait_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (fifo_level == 0) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    for (int m = 0; m < 5; m++) begin
      checks++;
      if (get_rd(m) !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd%0d: got %h want 0", m, get_rd(m));
      end
    end
    checks++;
    if (fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL reset_level: got %0d want 0", fifo_level);
    end
    checks++;
    if (err_sticky !== 1'b0 || waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: err %b wait %b want 0 0",
               err_sticky, waitrequest);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ppu_rw();
    logic [31:0] d;
    int qm[$];
    int qa[$];
    ppu_write(0, 5, 32'hDEAD_BEEF);
    ppu_read(0, 5, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL ppu_rd: got %h want deadbeef", d);
    end
    set_ppu(0, 1'b1, 5, 32'h0BAD_F00D);
    tick();
    checks++;
    if (rd_tb !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL ppu_rdw_old: got %h want deadbeef", rd_tb);
    end
    rw[0] = 1'b0;
    mdl[0][5] = 32'h0BAD_F00D;
    ppu_read(0, 5, d);
    checks++;
    if (d !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL ppu_rd_new: got %h want 0badf00d", d);
    end
    for (int i = 0; i < 24; i++) begin
      int m;
      int a;
      m = int'($urandom_range(0, 4));
      a = int'($urandom_range(0, depth_of(m) - 1));
      ppu_write(m, a, $urandom);
      qm.push_back(m);
      qa.push_back(a);
    end
    foreach (qm[i]) begin
      ppu_read(qm[i], qa[i], d);
      checks++;
      if (d !== mdl[qm[i]][qa[i]]) begin
        errors++;
        $display("FAIL ppu_rand m%0d a%0d: got %h want %h",
                 qm[i], qa[i], d, mdl[qm[i]][qa[i]]);
      end
    end
  endtask

  task automatic test_deferred();
    logic [31:0] d;
    bit ok;
    vblank = 1'b0;
    ppu_write(4, 3, 32'hA5A5_A5A5);
    host_push(4, 3, 32'h1234_5678, ok);
    checks++;
    if (!ok || fifo_level !== 5'd1) begin
      errors++;
      $display("FAIL defer_level: ok %b got %0d want 1",
               ok, fifo_level);
    end
    repeat (4) tick();
    ppu_read(4, 3, d);
    checks++;
    if (d !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL defer_hold: got %h want a5a5a5a5", d);
    end
    vblank = 1'b1;
    tick();
    tick();
    checks++;
    if (fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL defer_drain: got %0d want 0", fifo_level);
    end
    vblank = 1'b0;
    model_host(4, 3, 32'h1234_5678);
    ppu_read(4, 3, d);
    checks++;
    if (d !== 32'h1234_5678) begin
      errors++;
      $display("FAIL defer_commit: got %h want 12345678", d);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int qo[$];
    logic [31:0] qd[$];
    bit ok;
    bit acc;
    vblank = 1'b0;
    for (int i = 0; i < 17; i++) begin
      qo.push_back(int'($urandom_range(0, 2047)));
      qd.push_back($urandom);
    end
    for (int i = 0; i < 16; i++) begin
      host_push(0, qo[i], qd[i], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_push%0d: not accepted", i);
      end
    end
    checks++;
    if (fifo_level !== 5'd16 || waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: level %0d wait %b want 16 1",
               fifo_level, waitrequest);
    end
    chipselect = 1'b1;
    write      = 1'b1;
    address    = {3'd0, 11'(qo[16])};
    writedata  = qd[16];
    tick();
    checks++;
    if (waitrequest !== 1'b1 || fifo_level !== 5'd16) begin
      errors++;
      $display("FAIL bp_stall: wait %b level %0d want 1 16",
               waitrequest, fifo_level);
    end
    vblank = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (!waitrequest) acc = 1'b1;
      tick();
    end
    chipselect = 1'b0;
    write      = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL bp_17th: got stalled want accepted");
    end
    wait_empty(60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain: level %0d want 0", fifo_level);
    end
    vblank = 1'b0;
    tick();
    foreach (qo[i]) model_host(0, qo[i], qd[i]);
    foreach (qo[i]) begin
      ppu_read(0, qo[i] % 512, d);
      checks++;
      if (d !== mdl[0][qo[i] % 512]) begin
        errors++;
        $display("FAIL bp_data%0d: got %h want %h",
                 i, d, mdl[0][qo[i] % 512]);
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    logic [31:0] p;
    logic [31:0] d1;
    logic [31:0] d2;
    bit ok;
    bit hit;
    p  = $urandom;
    d1 = $urandom;
    d2 = $urandom;
    vblank = 1'b0;
    host_push(1, 300, d1, ok);
    host_push(1, 301, d2, ok);
    checks++;
    if (fifo_level !== 5'd2) begin
      errors++;
      $display("FAIL cf_level: got %0d want 2", fifo_level);
    end
    vblank = 1'b1;
    tick();
    set_ppu(1, 1'b1, 200, p);
    tick();
    rw[1] = 1'b0;
    mdl[1][200] = p;
    checks++;
    if (fifo_level !== 5'd2) begin
      errors++;
      $display("FAIL cf_nopop: got %0d want 2", fifo_level);
    end
    hit = 1'b0;
    for (int i = 0; i < 4 && !hit; i++) begin
      tick();
      if (fifo_level == 5'd1) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL cf_resume: level %0d want 1", fifo_level);
    end
    wait_empty(10, ok);
    vblank = 1'b0;
    tick();
    model_host(1, 300, d1);
    model_host(1, 301, d2);
    ppu_read(1, 300, d);
    checks++;
    if (d !== mdl[1][300]) begin
      errors++;
      $display("FAIL cf_d1: got %h want %h", d, mdl[1][300]);
    end
    ppu_read(1, 301, d);
    checks++;
    if (d !== mdl[1][301]) begin
      errors++;
      $display("FAIL cf_d2: got %h want %h", d, mdl[1][301]);
    end
    ppu_read(1, 200, d);
    checks++;
    if (d !== p) begin
      errors++;
      $display("FAIL cf_ppu: got %h want %h", d, p);
    end
  endtask

  task automatic test_vblank_drop();
    logic [31:0] d;
    int qs[$];
    int qo[$];
    logic [31:0] qd[$];
    bit ok;
    vblank = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        qs.push_back(qs[0]);
        qo.push_back(qo[0]);
      end else begin
        qs.push_back(int'($urandom_range(0, 4)));
        qo.push_back(int'($urandom_range(0, 2047)));
      end
      qd.push_back($urandom);
      host_push(qs[i], qo[i], qd[i], ok);
    end
    checks++;
    if (fifo_level !== 5'd8) begin
      errors++;
      $display("FAIL vd_level: got %0d want 8", fifo_level);
    end
    vblank = 1'b1;
    repeat (3) tick();
    vblank = 1'b0;
    checks++;
    if (fifo_level !== 5'd6) begin
      errors++;
      $display("FAIL vd_two: got %0d want 6", fifo_level);
    end
    repeat (5) tick();
    checks++;
    if (fifo_level !== 5'd6) begin
      errors++;
      $display("FAIL vd_stay: got %0d want 6", fifo_level);
    end
    vblank = 1'b1;
    wait_empty(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL vd_drain: level %0d want 0", fifo_level);
    end
    vblank = 1'b0;
    tick();
    foreach (qs[i]) model_host(qs[i], qo[i], qd[i]);
    foreach (qs[i]) begin
      int a;
      a = qo[i] % depth_of(qs[i]);
      ppu_read(qs[i], a, d);
      checks++;
      if (d !== mdl[qs[i]][a]) begin
        errors++;
        $display("FAIL vd_data%0d: got %h want %h",
                 i, d, mdl[qs[i]][a]);
      end
    end
  endtask

  task automatic test_edges();
    logic [31:0] d;
    bit ok;
    vblank = 1'b0;
    for (int m = 0; m < 5; m++) ppu_write(m, 5, $urandom);
    host_push(6, 5, 32'hCAFE_BABE, ok);
    host_push(3, 32'h0A, 32'hFFAA_BBCC, ok);
    vblank = 1'b1;
    wait_empty(20, ok);
    vblank = 1'b0;
    tick();
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL edge_err: got %b want 1", err_sticky);
    end
    for (int m = 0; m < 5; m++) begin
      ppu_read(m, 5, d);
      checks++;
      if (d !== mdl[m][5]) begin
        errors++;
        $display("FAIL edge_untouched%0d: got %h want %h",
                 m, d, mdl[m][5]);
      end
    end
    ppu_read(3, 2, d);
    checks++;
    if (d !== 32'h00AA_BBCC) begin
      errors++;
      $display("FAIL edge_cp: got %h want 00aabbcc", d);
    end
    for (int i = 0; i < 4; i++)
      host_push(2, int'($urandom_range(0, 2047)), $urandom, ok);
    vblank = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (fifo_level !== 5'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL edge_rst: level %0d err %b want 0 0",
               fifo_level, err_sticky);
    end
    repeat (3) tick();
    checks++;
    if (fifo_level !== 5'd0 || waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL edge_rst_stay: level %0d wait %b want 0 0",
               fifo_level, waitrequest);
    end
    vblank = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    vblank     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rw[i]  = 1'b0;
      pa[i]  = '0;
      pwd[i] = '0;
    end
    test_reset();
    test_ppu_rw();
    test_deferred();
    test_backpressure();
    test_conflict();
    test_vblank_drop();
    test_edges();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
